fb_mem_arbiter: RTL and testbench
=================================

Name: fb_mem_arbiter

Overview:
- Shares the single-port 4 KiB CHIP-8 memory between two requesters: the CPU and a framebuffer scan-out sequencer.
- On each frame start, the sequencer streams the 256-byte framebuffer (0x100–0x1FF) to the display driver over a valid/ready interface.
- The CPU has priority. A starvation guard guarantees the scanner forward progress.
- Sits between cpu, mem and the display driver in the top level.

Parameters:
- FB_BASE, 12'h100, first framebuffer byte address.
- FB_BYTES, 256, bytes per frame (64x32 bits / 8).
- STARVE_LIMIT, 8, consecutive denied scanner cycles before the scanner is forced a slot.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU memory access request, held until granted
- cpu_we  in  1  CPU write enable
- cpu_addr  in  12  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_gnt  out  1  CPU access issued to memory this cycle
- cpu_rvalid  out  1  cpu_rdata valid (cycle after a granted read)
- cpu_rdata  out  8  CPU read data
- frame_start  in  1  one-cycle pulse requesting a frame scan
- scan_data  out  8  framebuffer byte
- scan_valid  out  1  scan_data valid
- scan_ready  in  1  display driver accepts byte
- scan_last  out  1  marks byte FB_BYTES-1
- scan_busy  out  1  frame scan in progress
- frame_overrun  out  1  sticky: frame_start arrived while scan_busy
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  12  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  synchronous read data, valid one cycle after mem_en & !mem_we

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, index 0, FIFO empty, starve counter 0, overrun cleared.
- Sequencer states:
  - IDLE: frame_start -> SCAN, index=0.
  - SCAN: issue reads; when the read of index FB_BYTES-1 is issued -> DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight -> IDLE.
  - scan_busy = (state != IDLE).
- Scanner wants a slot when in SCAN and (FIFO occupancy + in-flight reads) < 2. The FIFO is 2 entries deep.
- Arbitration each cycle:
  - Scanner forced (starve counter == STARVE_LIMIT and scanner wants): scanner wins, cpu_gnt=0.
  - Else cpu_req: CPU wins, cpu_gnt=1.
  - Else scanner wants: scanner wins.
  - Else mem_en=0.
- Starve counter: increments when the scanner wants but loses; clears when the scanner is granted or does not want; saturates at STARVE_LIMIT.
- Memory port drive is combinational from the arbitration decision:
  - CPU grant: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - Scanner grant: mem_we=0, mem_addr=FB_BASE+index; index increments by 1.
- Tags: a one-bit registered tag routes mem_rdata the next cycle.
  - CPU read: cpu_rvalid=1, cpu_rdata=mem_rdata.
  - Scanner read: pushed into the FIFO, with the last flag when index was FB_BYTES-1.
- CPU writes produce no rvalid.
- CPU reads/writes into 0x100–0x1FF during a scan are allowed. Bytes already fetched are not refetched (tearing is acceptable).
- FIFO output:
  - scan_valid = not empty; scan_data and scan_last come from the head.
  - Pop on scan_valid & scan_ready.
  - Push and pop in the same cycle are legal at any occupancy ≤ 2.
  - scan_data holds stable while scan_valid & !scan_ready.
- frame_start while scan_busy: ignored; frame_overrun set to 1 and held until reset.
- frame_start in the same cycle as the DRAIN->IDLE transition: ignored and flagged as overrun.
- Index width is log2(FB_BYTES) + 1 bits. No wrap: index never exceeds FB_BYTES.

Decomposition:
- Shared package/header (chip8_defs.vh): FB_BASE, FB_BYTES, memory address width 12, data width 8, sequencer state encodings (IDLE, SCAN, DRAIN).
- One sub-module: fb_skid_fifo (2-entry, 9-bit wide {last,data}, push/pop/full/empty). Arbitration and sequencing stay in fb_mem_arbiter.

Test Plan:
- Idle frame: memory preloaded 0x100+i = i; frame_start pulse, scan_ready=1, cpu_req=0 -> 256 bytes 0x00..0xFF in order; scan_last only on 0xFF; scan_busy drops within 3 cycles after the last pop; mem_en never asserted with mem_we=1.
- CPU priority: cpu_req held 1 continuous reads of 0x020 (holding 0x42) during a scan -> cpu_gnt low exactly 1 cycle in every 9 (STARVE_LIMIT=8); cpu_rvalid with 0x42 one cycle after each grant; the frame still completes with correct data.
- Backpressure: scan_ready toggled 1 cycle on / 3 off, plus a random pattern -> no byte lost or duplicated; scan_data stable while stalled; never more than 2 reads outstanding plus buffered.
- CPU write during scan: CPU writes 0xAA to 0x1F0 before the scanner reaches index 0xF0 -> streamed byte 240 = 0xAA.
- Overrun: second frame_start 10 cycles after the first -> frame_overrun=1 and sticky; exactly 256 bytes delivered; scan_busy then stays 0.
- Reset mid-scan: reset_n pulled low asynchronously (not on a clock edge) at byte 100 -> all outputs 0 immediately; after release, a new frame_start yields a full 256-byte frame from index 0.

Source files
------------

// File: rtl/fb_mem_arbiter_pkg.sv
// fb_mem_arbiter_pkg: shared widths, framebuffer geometry and sequencer types
// for the CPU / framebuffer scan-out memory arbiter.
package fb_mem_arbiter_pkg;

    localparam int AW = 12;
    localparam int DW = 8;

    localparam logic [AW-1:0] DEF_FB_BASE      = 12'h100;
    localparam int            DEF_FB_BYTES     = 256;
    localparam int            DEF_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } scan_beat_t;

endpackage

// File: rtl/fb_skid_fifo.sv
// fb_skid_fifo: 2-entry {last,data} FIFO between scanner reads and the display;
// a push is accepted while full only if the head is popped in the same cycle.
module fb_skid_fifo
    import fb_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  scan_beat_t din_i,
    output scan_beat_t dout_o,
    output logic       full_o,
    output logic       empty_o
);

    scan_beat_t mem_q [2];
    logic       wp_q;
    logic       rp_q;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = cnt_q == 2'd2;
    assign empty_o = cnt_q == 2'd0;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) mem_q[wp_q] <= din_i;
            wp_q  <= wp_q ^ do_push;
            rp_q  <= rp_q ^ do_pop;
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares the single-port CHIP-8 memory between the CPU (priority)
// and a framebuffer scan-out sequencer protected by a starvation guard.
module fb_mem_arbiter
    import fb_mem_arbiter_pkg::*;
#(
    parameter logic [AW-1:0] FB_BASE      = DEF_FB_BASE,
    parameter int            FB_BYTES     = DEF_FB_BYTES,
    parameter int            STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          frame_start,
    output logic [DW-1:0] scan_data,
    output logic          scan_valid,
    input  logic          scan_ready,
    output logic          scan_last,
    output logic          scan_busy,
    output logic          frame_overrun,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            IW         = $clog2(FB_BYTES) + 1;
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(FB_BYTES - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    seq_state_e    state_q;
    logic [IW-1:0] idx_q;
    logic [SW-1:0] starve_q;
    logic          rd_q;
    logic          rd_scan_q;
    logic          rd_last_q;
    logic          overrun_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    fifo_occ;
    scan_beat_t    fifo_din;
    scan_beat_t    fifo_dout;
    logic          scan_inflight;
    logic          scan_want;
    logic          scan_force;
    logic          scan_gnt;

    // Occupancy plus the read in flight bounds the FIFO, so a push never overflows.
    assign scan_inflight = rd_q && rd_scan_q;
    assign fifo_occ      = fifo_full ? 2'd2 : {1'b0, !fifo_empty};
    assign scan_want     = state_q == ST_SCAN && (fifo_occ + {1'b0, scan_inflight}) < 2'd2;
    assign scan_force    = scan_want && starve_q == STARVE_MAX;
    assign cpu_gnt       = reset_n && cpu_req && !scan_force;
    assign scan_gnt      = scan_want && !cpu_gnt;

    assign mem_en    = cpu_gnt || scan_gnt;
    assign mem_we    = cpu_gnt && cpu_we;
    assign mem_addr  = cpu_gnt ? cpu_addr : scan_gnt ? FB_BASE + AW'(idx_q) : '0;
    assign mem_wdata = cpu_gnt ? cpu_wdata : '0;

    assign cpu_rvalid    = rd_q && !rd_scan_q;
    assign cpu_rdata     = cpu_rvalid ? mem_rdata : '0;
    assign fifo_din      = {rd_last_q, mem_rdata};
    assign scan_valid    = !fifo_empty;
    assign scan_data     = scan_valid ? fifo_dout.data : '0;
    assign scan_last     = scan_valid && fifo_dout.last;
    assign scan_busy     = state_q != ST_IDLE;
    assign frame_overrun = overrun_q;

    fb_skid_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (scan_inflight),
        .pop_i   (scan_valid && scan_ready),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            starve_q  <= '0;
            rd_q      <= 1'b0;
            rd_scan_q <= 1'b0;
            rd_last_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rd_q      <= mem_en && !mem_we;
            rd_scan_q <= scan_gnt;
            rd_last_q <= scan_gnt && idx_q == LAST_IDX;
            starve_q  <= scan_want && !scan_gnt ? starve_q + SW'(starve_q != STARVE_MAX) : '0;
            if (frame_start && state_q != ST_IDLE) overrun_q <= 1'b1;
            if (state_q == ST_IDLE && frame_start) begin
                state_q <= ST_SCAN;
                idx_q   <= '0;
            end else begin
                if (scan_gnt) idx_q <= idx_q + IW'(1);
                if (scan_gnt && idx_q == LAST_IDX) state_q <= ST_DRAIN;
                if (state_q == ST_DRAIN && fifo_empty && !scan_inflight) state_q <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: directed scenarios against a behavioural memory model;
// inputs change 1 ns after posedge, outputs are sampled around the negedge.
module tb_fb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        frame_start = 1'b0;
    logic [7:0]  scan_data;
    logic        scan_valid;
    logic        scan_ready = 1'b0;
    logic        scan_last;
    logic        scan_busy;
    logic        frame_overrun;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  mem [4096];
    logic [7:0]  exp_fb [256];
    logic [7:0]  rx_data [$];
    logic        rx_last [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_err = 0;
    int          out_err = 0;
    int          we_cnt = 0;
    int          outstanding = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = '0;
    logic [43:0] all_outs;

    assign all_outs = {cpu_gnt, cpu_rvalid, cpu_rdata, scan_data, scan_valid, scan_last,
                       scan_busy, frame_overrun, mem_en, mem_we, mem_addr, mem_wdata};

    fb_mem_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_gnt       (cpu_gnt),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .frame_start   (frame_start),
        .scan_data     (scan_data),
        .scan_valid    (scan_valid),
        .scan_ready    (scan_ready),
        .scan_last     (scan_last),
        .scan_busy     (scan_busy),
        .frame_overrun (frame_overrun),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    // Monitor: records every accepted byte and tracks stall stability and reads outstanding.
    always @(negedge clk) begin
        int o;
        if (!reset_n) begin
            stall_prev  <= 1'b0;
            outstanding <= 0;
        end else begin
            if (stall_prev && (!scan_valid || scan_data !== stall_data)) stall_err <= stall_err + 1;
            stall_prev <= scan_valid && !scan_ready;
            stall_data <= scan_data;
            if (mem_en && mem_we) we_cnt <= we_cnt + 1;
            o = outstanding + ((mem_en && !cpu_gnt) ? 1 : 0);
            if (o > 2) out_err <= out_err + 1;
            if (scan_valid && scan_ready) begin
                rx_data.push_back(scan_data);
                rx_last.push_back(scan_last);
                o = o - 1;
            end
            outstanding <= o;
        end
    end

    task automatic pulse_frame;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int base, input int budget, output int n_got, output int lag);
        int c = 0;
        while (rx_data.size() < base + 256 && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        lag = 0;
        while (scan_busy && lag < 10) begin
            @(negedge clk); #1;
            lag++;
        end
        n_got = rx_data.size() - base;
    endtask

    task automatic frame_stats(input int base, output int bad, output int first_bad);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (base + i >= rx_data.size() || rx_data[base+i] !== exp_fb[i] ||
                rx_last[base+i] !== (i == 255)) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h expected 0", all_outs);
        end
        n_checks++;
        if (frame_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overrun: got %b expected 0", frame_overrun);
        end
    endtask

    task automatic test_idle_frame;
        int base, n, lag, bad, fb, we0;
        @(posedge clk); #1;
        scan_ready = 1'b1;
        base = rx_data.size();
        we0 = we_cnt;
        pulse_frame();
        wait_frame(base, 2000, n, lag);
        frame_stats(base, bad, fb);
        n_checks++;
        if (n !== 256) begin n_fail++; $display("FAIL idle_count: got %0d expected 256", n); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL idle_data: got %0d bad (first %0d) expected 0", bad, fb); end
        n_checks++;
        if (lag > 3) begin n_fail++; $display("FAIL idle_busy_drop: got %0d cycles expected <=3", lag); end
        n_checks++;
        if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL idle_no_write: got %0d writes expected 0", we_cnt - we0); end
    endtask

    task automatic test_cpu_priority;
        int base, n, bad, fb, lows, last_low, gap_err, rv_err;
        logic prev_gnt;
        @(posedge clk); #1;
        scan_ready = 1'b1;
        base = rx_data.size();
        pulse_frame();
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 12'h020;
        prev_gnt = 1'b0;
        lows = 0;
        last_low = -1;
        gap_err = 0;
        rv_err = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            if (cpu_rvalid !== prev_gnt || (prev_gnt && cpu_rdata !== 8'h42)) rv_err++;
            if (scan_busy && !cpu_gnt) begin
                lows++;
                if (last_low >= 0 && c - last_low != 9) gap_err++;
                last_low = c;
            end
            prev_gnt = cpu_gnt;
            if (!scan_busy) break;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        n = rx_data.size() - base;
        frame_stats(base, bad, fb);
        n_checks++;
        if (lows !== 256) begin n_fail++; $display("FAIL prio_scan_slots: got %0d expected 256", lows); end
        n_checks++;
        if (gap_err !== 0) begin n_fail++; $display("FAIL prio_gap_9: got %0d bad gaps expected 0", gap_err); end
        n_checks++;
        if (rv_err !== 0) begin n_fail++; $display("FAIL prio_rvalid: got %0d errors expected 0", rv_err); end
        n_checks++;
        if (n !== 256) begin n_fail++; $display("FAIL prio_count: got %0d expected 256", n); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL prio_data: got %0d bad (first %0d) expected 0", bad, fb); end
    endtask

    task automatic test_backpressure;
        int base, n, lag, bad, fb, st0, out0, c;
        @(posedge clk); #1;
        base = rx_data.size();
        st0 = stall_err;
        out0 = out_err;
        pulse_frame();
        c = 0;
        while (rx_data.size() < base + 256 && c < 4000) begin
            scan_ready = c < 600 ? (c % 4 == 0) : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            c++;
        end
        scan_ready = 1'b1;
        wait_frame(base, 100, n, lag);
        frame_stats(base, bad, fb);
        n_checks++;
        if (n !== 256) begin n_fail++; $display("FAIL bp_count: got %0d expected 256", n); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_data: got %0d bad (first %0d) expected 0", bad, fb); end
        n_checks++;
        if (stall_err - st0 !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_err - st0); end
        n_checks++;
        if (out_err - out0 !== 0) begin n_fail++; $display("FAIL bp_outstanding: got %0d overs expected 0", out_err - out0); end
    endtask

    task automatic test_cpu_write;
        int base, n, lag, bad, fb;
        logic got_gnt;
        @(posedge clk); #1;
        scan_ready = 1'b1;
        base = rx_data.size();
        pulse_frame();
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 12'h1F0;
        cpu_wdata = 8'hAA;
        got_gnt = 1'b0;
        for (int c = 0; c < 20 && !got_gnt; c++) begin
            @(negedge clk); #1;
            got_gnt = cpu_gnt;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        exp_fb[240] = 8'hAA;
        @(negedge clk); #1;
        n_checks++;
        if (got_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_grant: got %b expected 1", got_gnt); end
        n_checks++;
        if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b expected 0", cpu_rvalid); end
        wait_frame(base, 2000, n, lag);
        frame_stats(base, bad, fb);
        n_checks++;
        if (n !== 256) begin n_fail++; $display("FAIL wr_count: got %0d expected 256", n); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL wr_data: got %0d bad (first %0d) expected 0", bad, fb); end
        n_checks++;
        if (rx_data.size() <= base + 240 || rx_data[base+240] !== 8'hAA) begin
            n_fail++;
            $display("FAIL wr_byte240: got %h expected aa",
                     rx_data.size() > base + 240 ? rx_data[base+240] : 8'hxx);
        end
    endtask

    task automatic test_overrun;
        int base, n, lag, bad, fb, busy_seen;
        logic ov_before, ov_after;
        @(posedge clk); #1;
        scan_ready = 1'b1;
        base = rx_data.size();
        pulse_frame();
        repeat (9) @(posedge clk);
        #1;
        ov_before = frame_overrun;
        pulse_frame();
        ov_after = frame_overrun;
        wait_frame(base, 2000, n, lag);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (scan_busy) busy_seen++;
        end
        n = rx_data.size() - base;
        frame_stats(base, bad, fb);
        n_checks++;
        if (ov_before !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b expected 0", ov_before); end
        n_checks++;
        if (ov_after !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ov_after); end
        n_checks++;
        if (n !== 256) begin n_fail++; $display("FAIL ovr_count: got %0d expected 256", n); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL ovr_data: got %0d bad (first %0d) expected 0", bad, fb); end
        n_checks++;
        if (busy_seen !== 0 || frame_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_quiet_sticky: got busy=%0d ovr=%b expected busy=0 ovr=1", busy_seen, frame_overrun);
        end
    endtask

    task automatic test_reset_mid_scan;
        int base, n, lag, bad, fb, c;
        @(posedge clk); #1;
        scan_ready = 1'b1;
        base = rx_data.size();
        pulse_frame();
        c = 0;
        while (rx_data.size() < base + 100 && c < 2000) begin
            @(negedge clk); #1;
            c++;
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", all_outs); end
        @(negedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        base = rx_data.size();
        pulse_frame();
        wait_frame(base, 2000, n, lag);
        frame_stats(base, bad, fb);
        n_checks++;
        if (n !== 256) begin n_fail++; $display("FAIL midreset_count: got %0d expected 256", n); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL midreset_data: got %0d bad (first %0d) expected 0", bad, fb); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[256+i] = 8'(i);
            exp_fb[i] = 8'(i);
        end
        mem[12'h020] = 8'h42;
        test_reset();
        test_idle_frame();
        test_cpu_priority();
        test_backpressure();
        test_cpu_write();
        test_overrun();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
